// File: rtl/fifo_ecc_rd_ctrl.sv
// rtl/fifo_ecc_rd_ctrl.sv - ECC FIFO read controller with credit-based 3-entry output buffer
// Drains the ECC FIFO into a small skid buffer, counts SEC/DED events, halts on DED if asked.
`timescale 1ns/1ps
module fifo_ecc_rd_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        halt_on_ded,
  input  logic        clr_status,
  input  logic        fifo_empty,
  output logic        fifo_rd_en,
  input  logic [31:0] fifo_dout,
  input  logic        fifo_dout_valid,
  input  logic        fifo_sec_err,
  input  logic        fifo_ded_err,
  output logic        m_valid,
  output logic [31:0] m_data,
  output logic        m_err,
  input  logic        m_ready,
  output logic [15:0] sec_cnt,
  output logic [15:0] ded_cnt,
  output logic        halted
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] HALT  = 2'd3;

  logic [1:0]  state, state_nxt;
  logic        iss0, iss1;
  logic [1:0]  occ, wr_ptr, rd_ptr;
  logic [32:0] ob_mem [3];
  logic        push, pop, sec_evt, ded_evt, halt_evt;
  logic [1:0]  inflight;
  logic [2:0]  credits_used;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // A return is only accepted in the slot of a read we actually issued.
  assign push     = iss1 & fifo_dout_valid;
  assign pop      = m_valid & m_ready;
  assign sec_evt  = push & fifo_sec_err & ~fifo_ded_err;
  assign ded_evt  = push & fifo_ded_err;
  assign halt_evt = ded_evt & halt_on_ded;

  assign inflight     = {1'b0, iss0} + {1'b0, iss1};
  assign credits_used = {1'b0, occ} + {1'b0, inflight};

  // Registered occupancy only: a word popped this cycle frees its credit next cycle.
  assign fifo_rd_en = (state == RUN) & ~fifo_empty & (credits_used < 3'd3);

  assign m_valid         = (occ != 2'd0);
  assign {m_err, m_data} = ob_mem[rd_ptr];

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (enable) state_nxt = RUN;
      RUN: begin
        if (halt_evt)     state_nxt = HALT;
        else if (!enable) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (halt_evt)              state_nxt = HALT;
        else if (inflight == 2'd0) state_nxt = IDLE;
        else if (enable)           state_nxt = RUN;
      end
      HALT:    if (clr_status) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      halted  <= 1'b0;
      iss0    <= 1'b0;
      iss1    <= 1'b0;
      occ     <= 2'd0;
      wr_ptr  <= 2'd0;
      rd_ptr  <= 2'd0;
      sec_cnt <= 16'd0;
      ded_cnt <= 16'd0;
    end else begin
      state  <= state_nxt;
      halted <= (state_nxt == HALT);
      iss0   <= fifo_rd_en;
      iss1   <= iss0;
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
      if (clr_status)
        sec_cnt <= {15'd0, sec_evt};
      else if (sec_evt && sec_cnt != 16'hFFFF)
        sec_cnt <= sec_cnt + 16'd1;
      if (clr_status)
        ded_cnt <= {15'd0, ded_evt};
      else if (ded_evt && ded_cnt != 16'hFFFF)
        ded_cnt <= ded_cnt + 16'd1;
    end
  end

  // Storage is cleared on reset so the head word reads as zero when empty after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) ob_mem[i] <= 33'd0;
    end else if (push) begin
      ob_mem[wr_ptr] <= {fifo_ded_err, fifo_dout};
    end
  end

endmodule

// File: tb/tb_fifo_ecc_rd_ctrl.sv
// tb/tb_fifo_ecc_rd_ctrl.sv - directed self-checking bench for fifo_ecc_rd_ctrl
`timescale 1ns/1ps
module tb_fifo_ecc_rd_ctrl;

  typedef struct packed {
    logic [31:0] d;
    logic        sec;
    logic        ded;
  } word_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        halt_on_ded = 1'b0;
  logic        clr_status = 1'b0;
  logic        fifo_empty = 1'b1;
  logic        fifo_rd_en;
  logic [31:0] fifo_dout = 32'd0;
  logic        fifo_dout_valid = 1'b0;
  logic        fifo_sec_err = 1'b0;
  logic        fifo_ded_err = 1'b0;
  logic        m_valid;
  logic [31:0] m_data;
  logic        m_err;
  logic        m_ready = 1'b0;
  logic [15:0] sec_cnt;
  logic [15:0] ded_cnt;
  logic        halted;

  always #5 clk = ~clk;

  fifo_ecc_rd_ctrl dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .halt_on_ded(halt_on_ded),
    .clr_status(clr_status), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
    .fifo_dout(fifo_dout), .fifo_dout_valid(fifo_dout_valid),
    .fifo_sec_err(fifo_sec_err), .fifo_ded_err(fifo_ded_err),
    .m_valid(m_valid), .m_data(m_data), .m_err(m_err), .m_ready(m_ready),
    .sec_cnt(sec_cnt), .ded_cnt(ded_cnt), .halted(halted)
  );

  // ECC FIFO model: rd_en sampled at edge k, data valid across edge k+2.
  word_t src [128];
  int    src_n = 0;
  int    src_rd = 0;
  word_t s1_w = '0, s2_w = '0;
  logic  s1_v = 1'b0, s2_v = 1'b0;
  int    drop_req = 0, drop_done = 0, dropped = 0;
  int    spur_req = 0, spur_done = 0;

  always @(negedge clk) begin
    fifo_dout_valid = s2_v;
    fifo_dout       = s2_w.d;
    fifo_sec_err    = s2_w.sec;
    fifo_ded_err    = s2_w.ded;
    if (s2_v && drop_req != drop_done) begin
      fifo_dout_valid = 1'b0;
      drop_done++;
      dropped++;
    end else if (!s2_v && spur_req != spur_done) begin
      fifo_dout_valid = 1'b1;
      fifo_dout       = 32'h5EED0001;
      fifo_sec_err    = 1'b1;
      fifo_ded_err    = 1'b1;
      spur_done++;
    end
    s2_v = s1_v;
    s2_w = s1_w;
    s1_v = 1'b0;
    fifo_empty = (src_rd == src_n);
    #1;
    if (fifo_rd_en && src_rd != src_n) begin
      s1_w = src[src_rd];
      s1_v = 1'b1;
      src_rd++;
    end
  end

  // Output capture and independent credit bookkeeping (reads issued minus words gone).
  logic [32:0] got [$];
  int issued = 0, popped = 0, rd_cnt = 0, credit_viol = 0;
  int trk_adj = 0;

  always @(negedge clk) begin
    #2;
    if (rst_n) begin
      if (fifo_rd_en) begin
        if (issued - popped - dropped - trk_adj >= 3) credit_viol++;
        issued++;
        rd_cnt++;
      end
      if (m_valid && m_ready) begin
        got.push_back({m_err, m_data});
        popped++;
      end
    end
  end

  int n_pass = 0;
  int n_chk  = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic load(input logic [31:0] d, input logic sec, input logic ded);
    src[src_n] = '{d: d, sec: sec, ded: ded};
    src_n++;
  endtask

  task automatic wait_got(input int n, input int budget, input string tag);
    int k = 0;
    while (got.size() < n && k < budget) begin
      @(negedge clk);
      #3;
      k++;
    end
    chk(tag, 64'(got.size() >= n), 64'd1);
  endtask

  initial begin
    int base, rd0, k, rd_halt;

    // reset state
    repeat (2) @(negedge clk);
    #3;
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_m_err", m_err, 0);
    chk("rst_sec_cnt", sec_cnt, 0);
    chk("rst_ded_cnt", ded_cnt, 0);
    chk("rst_halted", halted, 0);
    chk("rst_rd_en", fifo_rd_en, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // 16 in-order words with m_ready held high
    @(negedge clk);
    #3;
    base = got.size();
    rd0  = rd_cnt;
    for (int i = 0; i < 16; i++) load(32'hBEEF0000 + 32'(i), 1'b0, 1'b0);
    @(negedge clk);
    m_ready = 1'b1;
    enable  = 1'b1;
    wait_got(base + 16, 200, "t24_timeout");
    for (int i = 0; i < 16; i++)
      chk("t24_word", 64'(got[base + i]), {31'd0, 1'b0, 32'hBEEF0000 + 32'(i)});
    repeat (5) @(negedge clk);
    #3;
    chk("t24_rd_count", 64'(rd_cnt - rd0), 64'd16);
    chk("t24_sec_cnt", sec_cnt, 0);
    chk("t24_ded_cnt", ded_cnt, 0);
    chk("t24_idle_rd_en", fifo_rd_en, 0);
    chk("t24_halted", halted, 0);
    chk("t24_credit", 64'(credit_viol), 64'd0);

    // same stream with m_ready toggling every cycle
    base = got.size();
    for (int i = 0; i < 16; i++) load(32'hBEEF0000 + 32'(i), 1'b0, 1'b0);
    k = 0;
    while (got.size() < base + 16 && k < 300) begin
      @(negedge clk);
      m_ready = ~m_ready;
      #3;
      k++;
    end
    chk("t25_timeout", 64'(got.size() >= base + 16), 64'd1);
    @(negedge clk);
    m_ready = 1'b1;
    repeat (5) @(negedge clk);
    #3;
    chk("t25_count", 64'(got.size() - base), 64'd16);
    for (int i = 0; i < 16; i++)
      chk("t25_word", 64'(got[base + i]), {31'd0, 1'b0, 32'hBEEF0000 + 32'(i)});
    chk("t25_credit", 64'(credit_viol), 64'd0);

    // corrected single-bit word
    @(negedge clk);
    clr_status = 1'b1;
    @(negedge clk);
    clr_status = 1'b0;
    m_ready    = 1'b0;
    #3;
    load(32'hCAFED00D, 1'b1, 1'b0);
    k = 0;
    while (!m_valid && k < 20) begin
      @(negedge clk);
      #3;
      k++;
    end
    chk("t26_m_valid", m_valid, 1);
    chk("t26_m_data", m_data, 32'hCAFED00D);
    chk("t26_m_err", m_err, 0);
    chk("t26_sec_cnt", sec_cnt, 1);
    chk("t26_ded_cnt", ded_cnt, 0);
    @(negedge clk);
    m_ready = 1'b1;
    repeat (2) @(negedge clk);

    // stray valid ignored, dropped return frees its credit without a push
    m_ready = 1'b0;
    spur_req++;
    repeat (4) @(negedge clk);
    #3;
    chk("t08_no_push", m_valid, 0);
    chk("t08_sec_cnt", sec_cnt, 1);
    chk("t08_ded_cnt", ded_cnt, 0);
    @(negedge clk);
    m_ready = 1'b1;
    #3;
    base = got.size();
    drop_req++;
    load(32'hD0D00001, 1'b1, 1'b0);
    load(32'hD0D00002, 1'b0, 1'b0);
    wait_got(base + 1, 40, "t07_timeout");
    repeat (6) @(negedge clk);
    #3;
    chk("t07_count", 64'(got.size() - base), 64'd1);
    chk("t07_word", 64'(got[base]), {31'd0, 1'b0, 32'hD0D00002});
    chk("t07_sec_cnt", sec_cnt, 1);
    chk("t07_credit", 64'(credit_viol), 64'd0);

    // DED halt on the third of eight words
    @(negedge clk);
    clr_status  = 1'b1;
    halt_on_ded = 1'b1;
    @(negedge clk);
    clr_status = 1'b0;
    #3;
    base = got.size();
    for (int i = 0; i < 8; i++) load(32'hE0000000 + 32'(i), 1'b0, (i == 2));
    k = 0;
    while (!halted && k < 60) begin
      @(negedge clk);
      #3;
      k++;
    end
    chk("t27_halted", halted, 1);
    rd_halt = rd_cnt;
    repeat (6) @(negedge clk);
    #3;
    chk("t27_no_rd", 64'(rd_cnt - rd_halt), 64'd0);
    chk("t27_rd_en", fifo_rd_en, 0);
    chk("t27_ded_cnt", ded_cnt, 1);
    chk("t27_sec_cnt", sec_cnt, 0);
    chk("t27_err_word", 64'(got[base + 2]), {31'd0, 1'b1, 32'hE0000002});
    @(negedge clk);
    enable     = 1'b0;
    clr_status = 1'b1;
    @(negedge clk);
    clr_status = 1'b0;
    #3;
    chk("t27_clr_halted", halted, 0);
    chk("t27_clr_ded", ded_cnt, 0);
    repeat (3) @(negedge clk);
    #3;
    chk("t27_idle_no_rd", 64'(rd_cnt - rd_halt), 64'd0);
    @(negedge clk);
    enable = 1'b1;
    wait_got(base + 8, 100, "t27_timeout");
    for (int i = 0; i < 8; i++)
      chk("t27_word", 64'(got[base + i]), {31'd0, (i == 2), 32'hE0000000 + 32'(i)});
    @(negedge clk);
    halt_on_ded = 1'b0;

    // enable dropped with two reads in flight
    enable = 1'b0;
    repeat (4) @(negedge clk);
    #3;
    base = got.size();
    rd0  = rd_cnt;
    load(32'h28000000, 1'b0, 1'b0);
    load(32'h28000001, 1'b0, 1'b0);
    @(negedge clk);
    enable = 1'b1;
    @(negedge clk);
    @(negedge clk);
    enable = 1'b0;
    wait_got(base + 2, 40, "t28_timeout");
    chk("t28_word0", 64'(got[base]), {31'd0, 1'b0, 32'h28000000});
    chk("t28_word1", 64'(got[base + 1]), {31'd0, 1'b0, 32'h28000001});
    repeat (4) @(negedge clk);
    #3;
    chk("t28_rd_count", 64'(rd_cnt - rd0), 64'd2);
    chk("t28_rd_en", fifo_rd_en, 0);

    // reset with two words buffered and one still returning
    @(negedge clk);
    m_ready = 1'b0;
    enable  = 1'b1;
    #3;
    base = got.size();
    load(32'h28100000, 1'b0, 1'b0);
    load(32'h28100001, 1'b0, 1'b0);
    load(32'h28100002, 1'b1, 1'b0);
    k = 0;
    while (!m_valid && k < 20) begin
      @(negedge clk);
      #3;
      k++;
    end
    chk("t28_buffered", m_valid, 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("t28_rst_m_valid", m_valid, 0);
    chk("t28_rst_m_data", m_data, 0);
    #3;
    rst_n   = 1'b1;
    enable  = 1'b0;
    trk_adj = issued - popped - dropped;
    repeat (4) @(negedge clk);
    #3;
    chk("t28_post_m_valid", m_valid, 0);
    chk("t28_post_sec_cnt", sec_cnt, 0);
    chk("t28_post_rd_en", fifo_rd_en, 0);
    chk("t28_post_got", 64'(got.size() - base), 64'd0);

    // SEC counter saturation and clear racing an event
    @(negedge clk);
    force dut.sec_cnt = 16'hFFFF;
    #1;
    release dut.sec_cnt;
    #2;
    chk("t29_forced", sec_cnt, 16'hFFFF);
    @(negedge clk);
    enable  = 1'b1;
    m_ready = 1'b1;
    #3;
    base = got.size();
    load(32'h29000000, 1'b1, 1'b0);
    wait_got(base + 1, 40, "t29_timeout");
    repeat (2) @(negedge clk);
    #3;
    chk("t29_saturated", sec_cnt, 16'hFFFF);
    load(32'h29000001, 1'b1, 1'b0);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    clr_status = 1'b1;
    @(negedge clk);
    clr_status = 1'b0;
    #3;
    chk("t29_clr_with_evt", sec_cnt, 1);
    chk("t29_credit", 64'(credit_viol), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
